// File: rtl/pe_seq_if.sv
// pe_seq_if: single-master word bus between pe_seq and its memory or arbiter.
// A request (rd or wr) is held with stable address/data until ack completes it.
interface pe_seq_if #(
    parameter int AD_LEN    = 32,
    parameter int BUS_WIDTH = 32
);
    logic [AD_LEN-1:0]    bus_ad_o;
    logic [BUS_WIDTH-1:0] bus_data_o;
    logic                 bus_rd_o;
    logic                 bus_wr_o;
    logic [BUS_WIDTH-1:0] bus_data_i;
    logic                 bus_ack_i;

    modport master (
        output bus_ad_o, bus_data_o, bus_rd_o, bus_wr_o,
        input  bus_data_i, bus_ack_i
    );

    modport slave (
        input  bus_ad_o, bus_data_o, bus_rd_o, bus_wr_o,
        output bus_data_i, bus_ack_i
    );
endinterface

// File: rtl/pe_seq.sv
// pe_seq: sequencing PE -- FETCH/EXEC/MEM/STOP over a request/ack word bus.
// Define PE_MUL_EN to make opcode 11 a MUL; otherwise it faults like 12..15.
module pe_seq #(
    parameter int                AD_LEN    = 32,
    parameter int                BUS_WIDTH = 32,
    parameter int                NREGS     = 8,
    parameter logic [AD_LEN-1:0] RESET_VEC = '0
) (
    input  logic     clk_i,
    input  logic     reset_i,
    pe_seq_if.master bus,
    output logic     halted_o,
    output logic     fault_o
);
    localparam int RW    = $clog2(NREGS);
    localparam int IMM_W = BUS_WIDTH - 4 - 2 * RW;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_LD   = 4'd7;
    localparam logic [3:0] OP_ST   = 4'd8;
    localparam logic [3:0] OP_BNZ  = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd10;
`ifdef PE_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd11;
`endif

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_STOP} state_t;

    typedef struct packed {
        logic [3:0]       op;
        logic [RW-1:0]    rd;
        logic [RW-1:0]    rs;
        logic [IMM_W-1:0] imm;
    } instr_t;

    state_t                          state_q, state_d;
    logic [AD_LEN-1:0]               pc_q, pc_d;
    instr_t                          ir_q, ir_d;
    logic [NREGS-1:0][BUS_WIDTH-1:0] regs_q, regs_d;
    logic                            req_rd_q, req_rd_d;
    logic                            req_wr_q, req_wr_d;
    logic [AD_LEN-1:0]               ad_q, ad_d;
    logic [BUS_WIDTH-1:0]            wdata_q, wdata_d;
    logic                            halted_q, halted_d;
    logic                            fault_q, fault_d;

    logic [BUS_WIDTH-1:0] rd_val, rs_val, imm_ext;
    logic [AD_LEN-1:0]    pc_inc, mem_ad, npc;
    logic                 go_fetch;

    // Operands come from the registered file, so rd==rs reads the old value.
    assign rd_val  = regs_q[ir_q.rd];
    assign rs_val  = regs_q[ir_q.rs];
    assign imm_ext = BUS_WIDTH'(ir_q.imm);
    assign mem_ad  = AD_LEN'(rs_val);
    assign pc_inc  = pc_q + AD_LEN'(1);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        regs_d   = regs_q;
        req_rd_d = req_rd_q;
        req_wr_d = req_wr_q;
        ad_d     = ad_q;
        wdata_d  = wdata_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        go_fetch = 1'b0;
        npc      = pc_inc;

        case (state_q)
            S_FETCH: begin
                if (bus.bus_ack_i) begin
                    ir_d     = bus.bus_data_i;
                    req_rd_d = 1'b0;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                case (ir_q.op)
                    OP_NOP: go_fetch = 1'b1;
                    OP_LDI: begin
                        regs_d[ir_q.rd] = imm_ext;
                        go_fetch        = 1'b1;
                    end
                    OP_ADD: begin
                        regs_d[ir_q.rd] = rd_val + rs_val;
                        go_fetch        = 1'b1;
                    end
                    OP_SUB: begin
                        regs_d[ir_q.rd] = rd_val - rs_val;
                        go_fetch        = 1'b1;
                    end
                    OP_AND: begin
                        regs_d[ir_q.rd] = rd_val & rs_val;
                        go_fetch        = 1'b1;
                    end
                    OP_OR: begin
                        regs_d[ir_q.rd] = rd_val | rs_val;
                        go_fetch        = 1'b1;
                    end
                    OP_XOR: begin
                        regs_d[ir_q.rd] = rd_val ^ rs_val;
                        go_fetch        = 1'b1;
                    end
`ifdef PE_MUL_EN
                    OP_MUL: begin
                        regs_d[ir_q.rd] = rd_val * rs_val;
                        go_fetch        = 1'b1;
                    end
`endif
                    OP_LD: begin
                        state_d  = S_MEM;
                        req_rd_d = 1'b1;
                        ad_d     = mem_ad;
                    end
                    OP_ST: begin
                        state_d  = S_MEM;
                        req_wr_d = 1'b1;
                        ad_d     = mem_ad;
                        wdata_d  = rd_val;
                    end
                    OP_BNZ: begin
                        go_fetch = 1'b1;
                        if (rd_val != '0) npc = AD_LEN'(ir_q.imm);
                    end
                    OP_HALT: begin
                        state_d  = S_STOP;
                        halted_d = 1'b1;
                    end
                    default: begin
                        state_d  = S_STOP;
                        halted_d = 1'b1;
                        fault_d  = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (bus.bus_ack_i) begin
                    if (req_rd_q) regs_d[ir_q.rd] = bus.bus_data_i;
                    req_wr_d = 1'b0;
                    wdata_d  = '0;
                    go_fetch = 1'b1;
                end
            end
            default: ;
        endcase

        // Every path back to FETCH presents the next fetch on the bus right away.
        if (go_fetch) begin
            pc_d     = npc;
            state_d  = S_FETCH;
            req_rd_d = 1'b1;
            ad_d     = npc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_VEC;
            ir_q     <= '0;
            regs_q   <= '0;
            req_rd_q <= 1'b1;
            req_wr_q <= 1'b0;
            ad_q     <= RESET_VEC;
            wdata_q  <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            regs_q   <= regs_d;
            req_rd_q <= req_rd_d;
            req_wr_q <= req_wr_d;
            ad_q     <= ad_d;
            wdata_q  <= wdata_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.bus_ad_o   = ad_q;
    assign bus.bus_data_o = wdata_q;
    assign bus.bus_rd_o   = req_rd_q;
    assign bus.bus_wr_o   = req_wr_q;
    assign halted_o       = halted_q;
    assign fault_o        = fault_q;

    a_one_req: assert property (@(posedge clk_i) !(req_rd_q && req_wr_q));
    a_hold: assert property (@(posedge clk_i) disable iff (reset_i)
        ((req_rd_q || req_wr_q) && !bus.bus_ack_i) |=>
        ($stable(ad_q) && $stable(wdata_q) && $stable(req_rd_q) && $stable(req_wr_q)));
    a_stop: assert property (@(posedge clk_i) disable iff (reset_i)
        halted_q |=> (halted_q && !req_rd_q && !req_wr_q));
    a_fault: assert property (@(posedge clk_i) fault_q |-> halted_q);
endmodule

// File: doc/pe_seq.md
# pe_seq

Sequencing processing element: a parametrised PE that fetches instructions over a single-master word bus, executes them against a small register file, and issues data loads and stores on the same bus. It replaces the bus-idle PE stub in the CPU tile. The bus uses a request/acknowledge handshake so it can sit behind memories or arbiters with any wait-state count.

## Interface
- AD_LEN, 32, bus address width in bits; the address unit is one bus word.
- BUS_WIDTH, 32, data, register and instruction width; minimum 16.
- NREGS, 8, register count; power of two, 2..16.
- RESET_VEC, 0, PC value loaded on reset.
- clk_i  input  1  clock; all state changes on the rising edge.
- reset_i  input  1  reset; synchronous, active-high.
- bus_data_i  input  BUS_WIDTH  read data; valid when bus_ack_i is high.
- bus_ack_i  input  1  completes the pending request in this cycle.
- bus_ad_o  output  AD_LEN  request address.
- bus_data_o  output  BUS_WIDTH  write data; valid with bus_wr_o.
- bus_rd_o  output  1  read request.
- bus_wr_o  output  1  write request.
- halted_o  output  1  PE is stopped by HALT or a fault.
- fault_o  output  1  an illegal opcode was decoded.

## Operation
- Instruction word layout, MSB first:
  - opcode: 4 bits.
  - rd: log2(NREGS) bits.
  - rs: log2(NREGS) bits.
  - imm: the remaining low bits, zero-extended.
- Opcodes:
  - 0 NOP.
  - 1 LDI: rd = imm.
  - 2 ADD: rd = rd + rs.
  - 3 SUB: rd = rd - rs.
  - 4 AND, 5 OR, 6 XOR: rd = rd op rs.
  - 7 LD: rd = mem[rs].
  - 8 ST: mem[rs] = rd.
  - 9 BNZ: if rd != 0, pc = imm (absolute).
  - 10 HALT.
  - 11 MUL: see Configuration.
  - 12..15: illegal.
- Arithmetic wraps modulo 2^BUS_WIDTH.
- LD/ST address is rs truncated, or zero-extended, to AD_LEN bits.
- The PC increments by 1 per instruction and wraps modulo 2^AD_LEN.
- States and transitions:
  - FETCH: bus_rd_o=1, bus_ad_o=pc. When bus_ack_i=1, capture bus_data_i into IR and go to EXEC.
  - EXEC: decode and execute.
    - ALU ops, LDI and NOP write rd if applicable, set pc=pc+1, then go to FETCH.
    - BNZ updates pc, then goes to FETCH.
    - LD and ST go to MEM.
    - HALT goes to STOP.
    - An illegal opcode sets fault_o and goes to STOP.
  - MEM: LD asserts bus_rd_o; ST asserts bus_wr_o with bus_data_o=rd. Both use bus_ad_o=rs address. On bus_ack_i=1, LD writes bus_data_i into rd; then pc=pc+1 and go to FETCH.
  - STOP: no requests; halted_o=1. Leave STOP only through reset.
- Request rules:
  - A request stays asserted with stable address and data until acknowledged.
  - bus_rd_o and bus_wr_o are never high together.
  - bus_ack_i is ignored while no request is asserted.
- A register used as both rd and rs reads the old value; for example, ADD r1,r1 doubles r1.

## Timing
- Reset values:
  - pc = RESET_VEC.
  - All registers and IR are 0.
  - State is FETCH, so bus_rd_o=1 with bus_ad_o=RESET_VEC in the first cycle after reset.
  - bus_wr_o=0, bus_data_o=0, halted_o=0, fault_o=0.
- All outputs are registered.
- Zero-wait bus (ack in the first request cycle):
  - ALU, LDI, NOP, BNZ, HALT: 2 cycles each.
  - LD, ST: 3 cycles each.
- Each cycle with bus_ack_i=0 adds one cycle to the pending state.
- Reset asserted mid-request drops the request at that edge; the pending ack is not consumed.
- Register writes become visible to the next instruction.
- HALT and fault: halted_o rises the cycle after EXEC; fault_o rises with halted_o and stays high until reset.

## Configuration
- PE_MUL_EN defined: opcode 11 is MUL, rd = low BUS_WIDTH bits of rd * rs, executed in EXEC with no extra latency.
- PE_MUL_EN undefined: opcode 11 is illegal (fault_o, STOP), and no multiplier is synthesised.

## Test plan
- Reset release, ack held high → first request is bus_rd_o=1 at address 0; consecutive NOPs fetch from addresses 0,1,2, one fetch every 2 cycles.
- LDI r1,5; LDI r2,3; SUB r1,r2; ST r1→[r2] → write cycle shows bus_ad_o=3 and bus_data_o=2.
- LD with ack delayed 4 cycles → bus_rd_o, bus_ad_o and state held for 4 extra cycles; rd equals bus_data_i sampled on the ack cycle.
- Countdown loop, r1=3, SUB and BNZ back to the loop start → body executes 3 times; then HALT gives halted_o=1, fault_o=0, and no further requests.
- Opcode 14, and opcode 11 without PE_MUL_EN → fault_o=1 and halted_o=1 next cycle; with PE_MUL_EN, MUL of r=0xFFFF_FFFF by 2 gives 0xFFFF_FFFE.
- reset_i pulsed while a ST waits for ack → bus_wr_o=0 at the next edge, then a fetch from RESET_VEC; a stale ack arriving in the reset cycle has no effect.
